// File: rtl/cache_line_memory_pkg.sv
// Shared types and sizing helpers for the cache backing-memory responder.
package cache_mem_pkg;

  typedef enum logic [2:0] {IDLE, WAIT, READ, WRITE, ACK} state_e;

  localparam int unsigned REQ_ADDR_W = 32;

  typedef struct packed {
    logic                  write;
    logic [REQ_ADDR_W-1:0] addr;
  } line_req_t;

  function automatic int unsigned byte_off_bits(input int unsigned word_width);
    return $clog2(word_width / 8);
  endfunction

  function automatic int unsigned line_off_bits(input int unsigned words_per_line,
                                                input int unsigned word_width);
    return $clog2(words_per_line * word_width / 8);
  endfunction

  function automatic int unsigned word_idx_bits(input int unsigned depth_words);
    return $clog2(depth_words);
  endfunction

  function automatic int unsigned beat_cnt_bits(input int unsigned words_per_line);
    return $clog2(words_per_line);
  endfunction

endpackage

// File: rtl/cache_line_memory_mem_word_array.sv
// Word array: synchronous write, asynchronous read, one shared address.
module mem_word_array import cache_mem_pkg::*; #(
  parameter int unsigned WORD_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                                  clk,
  input  logic                                  we,
  input  logic [word_idx_bits(DEPTH_WORDS)-1:0] addr,
  input  logic [WORD_WIDTH-1:0]                 wdata,
  output logic [WORD_WIDTH-1:0]                 rdata
);

  logic [WORD_WIDTH-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/cache_line_memory.sv
// Backing-memory responder for cache line refill/writeback.
// CACHE_MEM_RANGE_CHECK_EN flags requests beyond the array instead of wrapping.
module cache_line_memory #(
  parameter int unsigned WORD_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned DEPTH_WORDS    = 1024,
  parameter int unsigned LATENCY        = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [WORD_WIDTH-1:0] wr_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WORD_WIDTH-1:0] resp_data,
  output logic                  resp_last,
  output logic                  resp_err
);
  import cache_mem_pkg::*;

  localparam int unsigned BYTE_BITS = byte_off_bits(WORD_WIDTH);
  localparam int unsigned BEAT_W    = beat_cnt_bits(WORDS_PER_LINE);
  localparam int unsigned IDX_W     = word_idx_bits(DEPTH_WORDS);
  localparam int unsigned LAT_W     = $clog2(LATENCY + 1);
  localparam int unsigned FULL_W    = ADDR_WIDTH - BYTE_BITS;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(LATENCY);

  state_e                  state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [LAT_W-1:0]        lat_q, lat_d;
  logic [IDX_W-BEAT_W-1:0] line_q, line_d;
  logic                    write_q, write_d;
  logic                    err_q, err_d;

  logic [FULL_W-1:0]     word_idx;
  logic                  range_err;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_addr;
  logic [WORD_WIDTH-1:0] mem_rdata;
  logic                  unused_addr_bits;

  assign word_idx = req_addr[ADDR_WIDTH-1:BYTE_BITS];
  assign unused_addr_bits = ^{req_addr[BYTE_BITS-1:0], word_idx[BEAT_W-1:0],
                              word_idx[FULL_W-1:IDX_W]};

`ifdef CACHE_MEM_RANGE_CHECK_EN
  assign range_err = (word_idx >= FULL_W'(DEPTH_WORDS));
  assign resp_err  = resp_valid & err_q;
`else
  assign range_err = 1'b0;
  assign resp_err  = 1'b0;
`endif

  // Line offset is the beat counter itself, so a line never crosses its base.
  assign mem_addr = {line_q, beat_q};

  mem_word_array #(
    .WORD_WIDTH (WORD_WIDTH),
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(wr_data),
    .rdata(mem_rdata)
  );

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    lat_d      = lat_q;
    line_d     = line_q;
    write_d    = write_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    wr_ready   = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    resp_last  = 1'b0;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          line_d  = word_idx[IDX_W-1:BEAT_W];
          write_d = req_write;
          err_d   = range_err;
          lat_d   = LAT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        lat_d = lat_q - 1'b1;
        if (lat_q == LAT_W'(1)) state_d = write_q ? WRITE : READ;
      end
      READ: begin
        resp_valid = 1'b1;
        resp_last  = (beat_q == LAST_BEAT);
        resp_data  = err_q ? '0 : mem_rdata;
        if (resp_ready) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = IDLE;
        end
      end
      WRITE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          mem_we = ~err_q;
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = ACK;
        end
      end
      ACK: begin
        resp_valid = 1'b1;
        resp_last  = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      lat_q   <= '0;
      line_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      line_q  <= line_d;
      write_q <= write_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_cache_line_memory.sv
// Directed bench for cache_line_memory; honours CACHE_MEM_RANGE_CHECK_EN.
module tb_cache_line_memory;

  localparam int unsigned LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_data = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        resp_last;
  logic        resp_err;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] ew [4];

  cache_line_memory #(
    .WORD_WIDTH    (32),
    .ADDR_WIDTH    (32),
    .WORDS_PER_LINE(4),
    .DEPTH_WORDS   (1024),
    .LATENCY       (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_last (resp_last),
    .resp_err  (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic wr, input logic [31:0] addr, input bit hold);
    int t = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_first(input bit wr);
    int n = 0;
    while (!(wr ? wr_ready : resp_valid) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(wr ? "wr_latency" : "rd_latency", 32'(n), 32'(LAT + 1));
  endtask

  task automatic recv_line(input int stall_beat, input int stall_n, input logic exp_err);
    bit busy_ok = 1'b1;
    bit hold_ok = 1'b1;
    for (int b = 0; b < 4; b++) begin
      int t = 0;
      while (!resp_valid && t < 50) begin
        @(negedge clk);
        busy_ok &= !req_ready;
        t++;
      end
      check($sformatf("rd_valid%0d", b), 32'(resp_valid), 32'd1);
      if (b == stall_beat) begin
        repeat (stall_n) begin
          @(negedge clk);
          hold_ok &= resp_valid && (resp_data == ew[b]) && (resp_last == (b == 3));
        end
        check("rd_stall_hold", 32'(hold_ok), 32'd1);
      end
      check($sformatf("rd_data%0d", b), resp_data, ew[b]);
      check($sformatf("rd_last%0d", b), 32'(resp_last), 32'(b == 3));
      check($sformatf("rd_err%0d", b), 32'(resp_err), 32'(exp_err));
      busy_ok &= !req_ready;
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
    end
    check("rd_busy_no_req", 32'(busy_ok), 32'd1);
    check("rd_no_extra_beat", 32'(resp_valid), 32'd0);
  endtask

  task automatic send_line(input logic exp_err);
    int t;
    for (int b = 0; b < 4; b++) begin
      wr_valid = 1'b1;
      wr_data  = ew[b];
      t = 0;
      while (!wr_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      check($sformatf("wr_ready%0d", b), 32'(wr_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0;
    t = 0;
    while (!resp_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("ack_valid", 32'(resp_valid), 32'd1);
    check("ack_last", 32'(resp_last), 32'd1);
    check("ack_data", resp_data, 32'd0);
    check("ack_err", 32'(resp_err), 32'(exp_err));
    check("ack_wr_ready", 32'(wr_ready), 32'd0);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("ack_done_idle", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for two cycles
    repeat (2) @(negedge clk);
    check("rst_resp_valid_held", 32'(resp_valid), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_resp_last", 32'(resp_last), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);

    // Known contents for line 0
    ew = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    do_req(1'b1, 32'h0, 1'b0);
    wait_first(1'b1);
    send_line(1'b0);

    // Writeback then refill of the same line via an unaligned address
    ew = '{32'd10, 32'd11, 32'd12, 32'd13};
    do_req(1'b1, 32'h40, 1'b0);
    wait_first(1'b1);
    send_line(1'b0);
    do_req(1'b0, 32'h44, 1'b0);
    wait_first(1'b0);
    recv_line(-1, 0, 1'b0);

    // Back-pressure on beat 2
    do_req(1'b0, 32'h40, 1'b0);
    wait_first(1'b0);
    recv_line(2, 3, 1'b0);

    // Reset in the middle of a refill
    do_req(1'b0, 32'h40, 1'b0);
    wait_first(1'b0);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("mid_beat1_data", resp_data, 32'd11);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    check("mid_rst_resp_last", 32'(resp_last), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    do_req(1'b0, 32'h40, 1'b0);
    wait_first(1'b0);
    recv_line(-1, 0, 1'b0);

    // Request at word index DEPTH_WORDS
    ew = '{32'd20, 32'd21, 32'd22, 32'd23};
    do_req(1'b1, 32'h1000, 1'b0);
    wait_first(1'b1);
`ifdef CACHE_MEM_RANGE_CHECK_EN
    send_line(1'b1);
    ew = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    do_req(1'b0, 32'h0, 1'b0);
    wait_first(1'b0);
    recv_line(-1, 0, 1'b0);
    ew = '{32'd0, 32'd0, 32'd0, 32'd0};
    do_req(1'b0, 32'h1000, 1'b0);
    wait_first(1'b0);
    recv_line(-1, 0, 1'b1);
`else
    send_line(1'b0);
    do_req(1'b0, 32'h0, 1'b0);
    wait_first(1'b0);
    recv_line(-1, 0, 1'b0);
`endif

    // Second request held high across the first transaction
    ew = '{32'd10, 32'd11, 32'd12, 32'd13};
    do_req(1'b0, 32'h40, 1'b1);
    wait_first(1'b0);
    recv_line(-1, 0, 1'b0);
    check("b2b_idle_gap", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    check("b2b_second_accepted", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    wait_first(1'b0);
    recv_line(-1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
